// File: rtl/instr_encoder_loader.sv
// Packs symbolic instruction beats into the 9-bit instruction format and
// streams the words into instruction memory at consecutive addresses.
module instr_encoder_loader #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned CNT_W  = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_class,
  input  logic [3:0]        in_opcode,
  input  logic [4:0]        in_operand,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [8:0]        imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  instr_count,
  output logic [CNT_W-1:0]  err_count
);

  localparam int unsigned    DATA_W   = 9;
  localparam logic [ADDR_W-1:0] MAX_ADDR = {ADDR_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;

  logic [ADDR_W-1:0]   r_ptr;
  logic                r_in_ready;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_busy;
  logic                r_done;
  logic                r_error;
  logic [CNT_W-1:0]    r_instr_count;
  logic [CNT_W-1:0]    r_err_count;

  logic [DATA_W-1:0]   w_enc;
  logic                w_enc_ok;
  logic                w_accept;
  logic                w_write;
  logic                w_reject;
  logic                w_ptr_max;
  logic                w_ovf;
  logic                w_term;
  logic                w_start_ok;

  // Instruction encoder: packs the beat and flags encodings the decoder cannot represent
  always_comb begin
    w_enc    = '0;
    w_enc_ok = 1'b0;
    case (in_class)
      2'b00: begin
        w_enc    = {2'b00, in_operand[2:0], in_opcode};
        w_enc_ok = (in_opcode[3] == 1'b0) && (in_operand[4:3] == 2'b00);
      end
      2'b01: begin
        w_enc    = {2'b01, in_opcode[2:0], in_operand[3:0]};
        w_enc_ok = (in_opcode[3:1] == 3'b000) && (in_operand[4] == 1'b0);
      end
      2'b10: begin
        w_enc    = {2'b10, in_opcode[1:0], in_operand};
        w_enc_ok = (in_opcode[3:2] == 2'b00);
      end
      default: begin
        // LSL/LSR (opcode 0/1) carry a 3-bit shift amount; BF/BB use all 5 bits
        w_enc    = {2'b11, in_opcode[1:0], in_operand};
        w_enc_ok = (in_opcode[3:2] == 2'b00) &&
                   (in_opcode[1] || (in_operand[4:3] == 2'b00));
      end
    endcase
  end

  always_comb begin
    w_accept   = (r_state == S_LOAD) && in_valid;
    w_write    = w_accept && w_enc_ok;
    w_reject   = w_accept && !w_enc_ok;
    w_ptr_max  = (r_ptr == MAX_ADDR);
    w_ovf      = w_write && w_ptr_max;
    w_term     = w_accept && (in_last || w_ovf);
    w_start_ok = start && (r_state != S_LOAD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_term) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (start) begin
          w_state_next = S_LOAD;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Status flags track the state being entered so they change on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_in_ready <= (w_state_next == S_LOAD);
      r_busy     <= (w_state_next == S_LOAD);
      r_done     <= (w_state_next == S_DONE);
    end
  end

  // Write port: one strobe cycle per valid beat; address and data hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= w_write;
      if (w_write) begin
        r_addr  <= r_ptr;
        r_wdata <= w_enc;
      end
    end
  end

  // Address pointer stops at the top of memory rather than wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_start_ok) begin
      r_ptr <= base_addr;
    end else if (w_write && !w_ptr_max) begin
      r_ptr <= r_ptr + ADDR_W'(1);
    end
  end

  // Session counters and sticky error, cleared when a session starts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_error       <= 1'b0;
      r_instr_count <= '0;
      r_err_count   <= '0;
    end else if (w_start_ok) begin
      r_error       <= 1'b0;
      r_instr_count <= '0;
      r_err_count   <= '0;
    end else begin
      if (w_reject || (w_ovf && !in_last)) begin
        r_error <= 1'b1;
      end
      if (w_write && (r_instr_count != CNT_MAX)) begin
        r_instr_count <= r_instr_count + CNT_W'(1);
      end
      if (w_reject && (r_err_count != CNT_MAX)) begin
        r_err_count <= r_err_count + CNT_W'(1);
      end
    end
  end

  assign in_ready    = r_in_ready;
  assign busy        = r_busy;
  assign done        = r_done;
  assign imem_we     = r_we;
  assign imem_addr   = r_addr;
  assign imem_wdata  = r_wdata;
  assign error       = r_error;
  assign instr_count = r_instr_count;
  assign err_count   = r_err_count;

endmodule
